// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM driving the ALU32 datapath: IF/ID/EXE/MEM/WB sequencing.
// Outputs are Moore on state (except branch PCSrc, combinational on zero); Reset low forces all outputs to 0.
module multicycle_control_unit #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    output logic [STW-1:0]  state,
    output logic            IRWre,
    output logic            PCWre,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUop,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            ExtSel,
    output logic [1:0]      RegDst,
    output logic            RegWre,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic            halted
);

    typedef enum logic [STW-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_NOR   = 6'b010011;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT   = 6'b100110;
    localparam logic [OPW-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    logic       is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_illegal;
    logic [2:0] dec_aluop;
    logic       dec_srca, dec_srcb, dec_ext;
    logic [1:0] dec_regdst;

    // Opcode decode; fields stay valid for the whole instruction because IR is stable from ID on.
    always_comb begin
        is_alu     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_halt    = 1'b0;
        dec_aluop  = 3'b000;
        dec_srca   = 1'b0;
        dec_srcb   = 1'b0;
        dec_ext    = 1'b0;
        dec_regdst = 2'b00;
        case (opcode)
            OP_ADD:   begin is_alu = 1'b1; dec_regdst = 2'b10; end
            OP_SUB:   begin is_alu = 1'b1; dec_aluop = 3'b001; dec_regdst = 2'b10; end
            OP_ADDIU: begin is_alu = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b1; dec_regdst = 2'b01; end
            OP_AND:   begin is_alu = 1'b1; dec_aluop = 3'b100; dec_regdst = 2'b10; end
            OP_ANDI:  begin is_alu = 1'b1; dec_aluop = 3'b100; dec_srcb = 1'b1; dec_regdst = 2'b01; end
            OP_ORI:   begin is_alu = 1'b1; dec_aluop = 3'b011; dec_srcb = 1'b1; dec_regdst = 2'b01; end
            OP_NOR:   begin is_alu = 1'b1; dec_aluop = 3'b111; dec_regdst = 2'b10; end
            OP_SLL:   begin is_alu = 1'b1; dec_aluop = 3'b010; dec_srca = 1'b1; dec_regdst = 2'b10; end
            OP_SLT:   begin is_alu = 1'b1; dec_aluop = 3'b110; dec_regdst = 2'b10; end
            OP_SLTIU: begin is_alu = 1'b1; dec_aluop = 3'b101; dec_srcb = 1'b1; dec_ext = 1'b1; dec_regdst = 2'b01; end
            OP_SW:    begin is_sw = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b1; dec_regdst = 2'b01; end
            OP_LW:    begin is_lw = 1'b1; dec_srcb = 1'b1; dec_ext = 1'b1; dec_regdst = 2'b01; end
            OP_BEQ:   begin is_beq = 1'b1; dec_aluop = 3'b001; dec_ext = 1'b1; end
            OP_BNE:   begin is_bne = 1'b1; dec_aluop = 3'b001; dec_ext = 1'b1; end
            OP_J:     is_j = 1'b1;
            OP_HALT:  is_halt = 1'b1;
            default:  ;
        endcase
        is_illegal = ~(is_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_halt);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            S_IF:     if (!halted_q) state_d = S_ID;
            S_ID: begin
                if (is_alu)                state_d = S_EXE_AL;
                else if (is_beq || is_bne) state_d = S_EXE_BR;
                else if (is_lw || is_sw)   state_d = S_EXE_LS;
                else begin
                    state_d  = S_IF;
                    halted_d = halted_q | is_halt;
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // Gating on Reset makes pending writes drop the instant Reset falls, not at the next edge.
    always_comb begin
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        ALUop     = 3'b000;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        RegDst    = 2'b00;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (Reset) begin
            if (state_q == S_IF) begin
                IRWre = ~halted_q;
            end else begin
                ALUop   = dec_aluop;
                ALUSrcA = dec_srca;
                ALUSrcB = dec_srcb;
                ExtSel  = dec_ext;
                RegDst  = dec_regdst;
            end
            case (state_q)
                S_ID: begin
                    if (is_j) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end else if (is_illegal) begin
                        PCWre = 1'b1;
                    end
                end
                S_WB_AL: begin
                    RegWre = 1'b1;
                    PCWre  = 1'b1;
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    if ((is_beq && zero) || (is_bne && !zero)) PCSrc = 2'b01;
                end
                S_MEM: begin
                    mRD   = is_lw;
                    mWR   = is_sw;
                    PCWre = is_sw;
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state  = state_q;
    assign halted = halted_q & Reset;

endmodule
